alu_exec_stage: RTL

ALU_EXEC_STAGE -- requirements
Module: alu_exec_stage

---
 rtl/alu_exec_stage.sv | 132 +++++++++++++
 1 files changed

// File: rtl/alu_exec_stage.sv
// Single-issue ALU execute stage. Non-MUL ops finish in one cycle; MUL is an
// iterative shift-add that stalls the stage for WIDTH cycles.
module alu_exec_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] imm,
  input  logic             use_imm,
  input  logic [1:0]       fwd_sel_a,
  input  logic [WIDTH-1:0] fwd_exmem,
  input  logic [WIDTH-1:0] fwd_memwb,
  input  logic             flush,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             busy
);
  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SLL = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_SRL = 3'b011;
  localparam logic [2:0] OP_SRA = 3'b100;
  localparam logic [2:0] OP_AND = 3'b101;
  localparam logic [2:0] OP_OR  = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic {IDLE, MUL_RUN} state_t;

  state_t             state;
  logic [SHW-1:0]     cnt;
  logic [2*WIDTH-1:0] acc, mcand, acc_nxt;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   opa, opb, alu_res;
  logic [SHW-1:0]     sh;
  logic [WIDTH:0]     sum, diff;
  logic               alu_c;

  assign in_ready = ~busy;

  always_comb begin
    case (fwd_sel_a)
      2'b01:   opa = fwd_exmem;
      2'b10:   opa = fwd_memwb;
      default: opa = a;
    endcase
    opb  = use_imm ? imm : b;
    sh   = opb[SHW-1:0];
    sum  = {1'b0, opa} + {1'b0, opb};
    diff = {1'b0, opa} - {1'b0, opb};
    alu_res = '0;
    alu_c   = 1'b0;
    case (op)
      OP_ADD: begin alu_res = sum[WIDTH-1:0];  alu_c = sum[WIDTH];   end
      OP_SUB: begin alu_res = diff[WIDTH-1:0]; alu_c = ~diff[WIDTH]; end
      OP_SLL: alu_res = opa << sh;
      OP_SRL: alu_res = opa >> sh;
      OP_SRA: alu_res = WIDTH'($signed(opa) >>> sh);
      OP_AND: alu_res = opa & opb;
      OP_OR:  alu_res = opa | opb;
      default: ;
    endcase
  end

  // One partial product per cycle; the last one is folded straight into result.
  assign acc_nxt = mplier[0] ? acc + mcand : acc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      cnt       <= '0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b1;
      carry     <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (flush) begin
        state <= IDLE;
        busy  <= 1'b0;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: if (in_valid) begin
            if (op == OP_MUL) begin
              state  <= MUL_RUN;
              busy   <= 1'b1;
              cnt    <= '0;
              acc    <= '0;
              mcand  <= {{WIDTH{1'b0}}, opa};
              mplier <= opb;
            end else begin
              result    <= alu_res;
              zero      <= (alu_res == '0);
              carry     <= alu_c;
              out_valid <= 1'b1;
            end
          end
          MUL_RUN: begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (cnt == LAST) begin
              state     <= IDLE;
              busy      <= 1'b0;
              cnt       <= '0;
              result    <= acc_nxt[WIDTH-1:0];
              zero      <= (acc_nxt[WIDTH-1:0] == '0);
              carry     <= |acc_nxt[2*WIDTH-1:WIDTH];
              out_valid <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
